// File: rtl/huffman_pkg.sv
// Shared constants, record layout and helpers for the Huffman tree builder
// and the downstream code generator.
package huffman_pkg;

  localparam int LEAVES = 4;
  localparam int NODES  = 2 * LEAVES - 1;
  localparam int W      = 8;
  localparam int IDXW   = 4;
  localparam int TW     = $clog2(NODES + 1);
  localparam int REC_W  = IDXW + 1 + W;

  // Node-record field offsets inside one REC_W-bit record
  localparam int REC_WEIGHT_LSB = 0;
  localparam int REC_BRANCH_BIT = W;
  localparam int REC_PARENT_LSB = W + 1;

  localparam logic [IDXW-1:0] ROOT_PARENT = 4'hF;
  localparam logic [IDXW-1:0] NO_NODE     = 4'h0;
  localparam logic [IDXW-1:0] LEAVES_IDX  = IDXW'(LEAVES);
  localparam logic [IDXW-1:0] NODES_IDX   = IDXW'(NODES);

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_BUILD = 2'b01;
  localparam logic [1:0] PH_CODE  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SCAN  = 3'd2,
    S_MERGE = 3'd3,
    S_DONE  = 3'd4
  } fsm_t;

  // Returns {carry, weight}; the weight saturates to all ones on carry.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[W]) begin
      return {1'b1, {W{1'b1}}};
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/huffman_tree_builder_min2_scan.sv
// Sequential two-minimum tracker: fed one node per cycle, keeps the two
// lightest active nodes seen since the last clear (ties keep the earlier one).
module huffman_min2_scan
  import huffman_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [IDXW-1:0] index,
  input  logic [W-1:0]    weight,
  input  logic            active,
  output logic [IDXW-1:0] min1_idx,
  output logic [IDXW-1:0] min2_idx
);

  logic [W-1:0] min1_w_r;
  logic [W-1:0] min2_w_r;

  // Running two-minimum update with strict less-than comparisons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min1_idx <= NO_NODE;
      min2_idx <= NO_NODE;
      min1_w_r <= '0;
      min2_w_r <= '0;
    end else if (clear) begin
      min1_idx <= NO_NODE;
      min2_idx <= NO_NODE;
      min1_w_r <= '0;
      min2_w_r <= '0;
    end else if (active) begin
      if ((min1_idx == NO_NODE) || (weight < min1_w_r)) begin
        min2_idx <= min1_idx;
        min2_w_r <= min1_w_r;
        min1_idx <= index;
        min1_w_r <= weight;
      end else if ((min2_idx == NO_NODE) || (weight < min2_w_r)) begin
        min2_idx <= index;
        min2_w_r <= weight;
      end
    end
  end

endmodule

// File: rtl/huffman_tree_builder.sv
// Huffman tree builder: loads LEAVES weights, then repeatedly scans for the
// two lightest active nodes and merges them until the root is formed.
module huffman_tree_builder
  import huffman_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     leaf_valid,
  input  logic [W-1:0]             leaf_weight,
  output logic                     leaf_ready,
  output logic [1:0]               state,
  output logic                     tree_valid,
  output logic                     overflow,
  output logic [NODES*REC_W-1:0]   info_nodes
);

  fsm_t fsm_r;
  fsm_t fsm_next_s;

  // Index 0 is the "none" slot and is never written
  logic [W-1:0]    weight_r [0:NODES];
  logic [IDXW-1:0] parent_r [0:NODES];
  logic            branch_r [0:NODES];
  logic [NODES:0]  active_r;

  logic [IDXW-1:0] leaf_cnt_r;
  logic [IDXW-1:0] nf_r;
  logic [IDXW-1:0] scan_idx_r;

  logic [IDXW-1:0] min1_idx_s;
  logic [IDXW-1:0] min2_idx_s;
  logic [IDXW-1:0] leaf_slot_s;
  logic            accept_s;
  logic            scan_last_s;
  logic            scan_clear_s;
  logic            scan_active_s;
  logic [W:0]      merge_sum_s;

  huffman_min2_scan u_scan (
    .clk      (clk),
    .rst      (rst),
    .clear    (scan_clear_s),
    .index    (scan_idx_r),
    .weight   (weight_r[scan_idx_r[TW-1:0]]),
    .active   (scan_active_s),
    .min1_idx (min1_idx_s),
    .min2_idx (min2_idx_s)
  );

  // Handshake, scan control and merge arithmetic
  always_comb begin
    leaf_ready    = (fsm_r == S_LOAD) && (leaf_cnt_r < LEAVES_IDX);
    accept_s      = leaf_valid & leaf_ready;
    leaf_slot_s   = leaf_cnt_r + 4'd1;
    scan_last_s   = (scan_idx_r == (nf_r - 4'd1));
    scan_clear_s  = (fsm_r != S_SCAN);
    scan_active_s = (fsm_r == S_SCAN) && active_r[scan_idx_r[TW-1:0]];
    merge_sum_s   = sat_add(weight_r[min1_idx_s[TW-1:0]], weight_r[min2_idx_s[TW-1:0]]);
  end

  // Next-state and phase outputs
  always_comb begin
    fsm_next_s = fsm_r;
    state      = PH_BUILD;
    tree_valid = 1'b0;
    case (fsm_r)
      S_IDLE: begin
        state = PH_IDLE;
        if (start) fsm_next_s = S_LOAD;
        else       fsm_next_s = S_IDLE;
      end
      S_LOAD: begin
        if (accept_s && (leaf_cnt_r == (LEAVES_IDX - 4'd1))) fsm_next_s = S_SCAN;
        else                                                 fsm_next_s = S_LOAD;
      end
      S_SCAN: begin
        if (scan_last_s) fsm_next_s = S_MERGE;
        else             fsm_next_s = S_SCAN;
      end
      S_MERGE: begin
        if (nf_r == NODES_IDX) fsm_next_s = S_DONE;
        else                   fsm_next_s = S_SCAN;
      end
      S_DONE: begin
        state      = PH_CODE;
        tree_valid = 1'b1;
        if (start) fsm_next_s = S_LOAD;
        else       fsm_next_s = S_DONE;
      end
      default: begin
        fsm_next_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_r <= S_IDLE;
    else     fsm_r <= fsm_next_s;
  end

  // Node table, counters and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NODES; k++) begin
        weight_r[TW'(k)] <= '0;
        parent_r[TW'(k)] <= NO_NODE;
        branch_r[TW'(k)] <= 1'b0;
      end
      active_r   <= '0;
      leaf_cnt_r <= 4'd0;
      nf_r       <= 4'd0;
      scan_idx_r <= 4'd0;
      overflow   <= 1'b0;
    end else begin
      case (fsm_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int k = 0; k <= NODES; k++) begin
              weight_r[TW'(k)] <= '0;
              parent_r[TW'(k)] <= NO_NODE;
              branch_r[TW'(k)] <= 1'b0;
            end
            active_r   <= '0;
            leaf_cnt_r <= 4'd0;
            overflow   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            weight_r[leaf_slot_s[TW-1:0]] <= leaf_weight;
            parent_r[leaf_slot_s[TW-1:0]] <= NO_NODE;
            branch_r[leaf_slot_s[TW-1:0]] <= 1'b0;
            active_r[leaf_slot_s[TW-1:0]] <= 1'b1;
            leaf_cnt_r <= leaf_slot_s;
            nf_r       <= LEAVES_IDX + 4'd1;
            scan_idx_r <= 4'd1;
          end
        end
        S_SCAN: begin
          scan_idx_r <= scan_idx_r + 4'd1;
        end
        S_MERGE: begin
          weight_r[nf_r[TW-1:0]]       <= merge_sum_s[W-1:0];
          active_r[nf_r[TW-1:0]]       <= 1'b1;
          parent_r[min1_idx_s[TW-1:0]] <= nf_r;
          branch_r[min1_idx_s[TW-1:0]] <= 1'b0;
          active_r[min1_idx_s[TW-1:0]] <= 1'b0;
          parent_r[min2_idx_s[TW-1:0]] <= nf_r;
          branch_r[min2_idx_s[TW-1:0]] <= 1'b1;
          active_r[min2_idx_s[TW-1:0]] <= 1'b0;
          if (merge_sum_s[W]) overflow <= 1'b1;
          if (nf_r == NODES_IDX) begin
            parent_r[nf_r[TW-1:0]] <= ROOT_PARENT;
            branch_r[nf_r[TW-1:0]] <= 1'b1;
          end else begin
            nf_r       <= nf_r + 4'd1;
            scan_idx_r <= 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Flatten the table; record k (1-based) sits at bits [REC_W*k-1 -: REC_W]
  always_comb begin
    info_nodes = '0;
    for (int k = 1; k <= NODES; k++) begin
      info_nodes[(k-1)*REC_W + REC_WEIGHT_LSB +: W]    = weight_r[TW'(k)];
      info_nodes[(k-1)*REC_W + REC_BRANCH_BIT]         = branch_r[TW'(k)];
      info_nodes[(k-1)*REC_W + REC_PARENT_LSB +: IDXW] = parent_r[TW'(k)];
    end
  end

endmodule

// File: tb/tb_huffman_tree_builder.sv
// Directed bench for huffman_tree_builder: table of leaf sets with
// hand-built trees, plus reset-mid-build and restart sequences.
module tb_huffman_tree_builder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        leaf_valid;
  logic [7:0]  leaf_weight;
  logic        leaf_ready;
  logic [1:0]  state;
  logic        tree_valid;
  logic        overflow;
  logic [90:0] info_nodes;

  huffman_tree_builder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .leaf_valid  (leaf_valid),
    .leaf_weight (leaf_weight),
    .leaf_ready  (leaf_ready),
    .state       (state),
    .tree_valid  (tree_valid),
    .overflow    (overflow),
    .info_nodes  (info_nodes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] w;
    logic [90:0]     info;
    logic            ovf;
  } vec_t;

  vec_t vecs [5];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [12:0] rec(input logic [3:0] p, input logic b, input logic [7:0] wt);
    return {p, b, wt};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"},      128'(state),      128'(2'b00));
    check({tag, " leaf_ready"}, 128'(leaf_ready), 128'(1'b0));
    check({tag, " tree_valid"}, 128'(tree_valid), 128'(1'b0));
    check({tag, " overflow"},   128'(overflow),   128'(1'b0));
    check({tag, " info_nodes"}, 128'(info_nodes), 128'(0));
  endtask

  // Pulse start for one cycle, then confirm the cleared LOAD state
  task automatic pulse_start(input int i);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d leaf_ready after start", i), 128'(leaf_ready), 128'(1'b1));
    check($sformatf("v%0d state after start", i),      128'(state),      128'(2'b01));
    check($sformatf("v%0d tree_valid after start", i), 128'(tree_valid), 128'(1'b0));
    check($sformatf("v%0d overflow after start", i),   128'(overflow),   128'(1'b0));
    check($sformatf("v%0d table cleared", i),          128'(info_nodes), 128'(0));
  endtask

  // Offer leaves with leaf_valid held high (optionally gapped); leaves the
  // bench just before the edge that accepts the last leaf
  task automatic load_leaves(input int i, input bit gaps, output int accepted);
    int cyc;
    accepted = 0;
    cyc = 0;
    while (accepted < 4 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (gaps && cyc[0] == 1'b0) begin
        leaf_valid  = 1'b0;
        leaf_weight = 8'hA5;
      end else begin
        leaf_valid  = 1'b1;
        leaf_weight = vecs[i].w[accepted];
      end
      if (leaf_valid && leaf_ready) accepted++;
    end
    check($sformatf("v%0d accepts", i), 128'(accepted), 128'(4));
  endtask

  task automatic run_vector(input int i, input bit gaps, input bit mid_start);
    int accepted;
    int edges;
    pulse_start(i);
    load_leaves(i, gaps, accepted);
    @(posedge clk);
    edges = 0;
    while (edges < 60) begin
      @(negedge clk);
      leaf_weight = 8'hEE;
      start = (mid_start && edges == 7) ? 1'b1 : 1'b0;
      if (edges == 0)
        check($sformatf("v%0d leaf_ready after last accept", i), 128'(leaf_ready), 128'(1'b0));
      if (tree_valid) break;
      @(posedge clk);
      edges++;
    end
    start = 1'b0;
    check($sformatf("v%0d latency", i),    128'(edges),      128'(18));
    check($sformatf("v%0d tree_valid", i), 128'(tree_valid), 128'(1'b1));
    check($sformatf("v%0d state", i),      128'(state),      128'(2'b10));
    check($sformatf("v%0d overflow", i),   128'(overflow),   128'(vecs[i].ovf));
    for (int k = 0; k < 7; k++) begin
      check($sformatf("v%0d node%0d", i, k + 1),
            128'(info_nodes[k*13 +: 13]), 128'(vecs[i].info[k*13 +: 13]));
    end
    leaf_valid = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("v%0d tree held", i), 128'(info_nodes), 128'(vecs[i].info));
  endtask

  initial begin
    int accepted;

    vecs[0].w    = {8'd13, 8'd12, 8'd9, 8'd5};
    vecs[0].info = {rec(4'hF,1'b1,8'd39), rec(4'd7,1'b1,8'd25), rec(4'd7,1'b0,8'd14),
                    rec(4'd6,1'b1,8'd13), rec(4'd6,1'b0,8'd12), rec(4'd5,1'b1,8'd9),
                    rec(4'd5,1'b0,8'd5)};
    vecs[0].ovf  = 1'b0;

    vecs[1].w    = {8'd10, 8'd10, 8'd10, 8'd10};
    vecs[1].info = {rec(4'hF,1'b1,8'd40), rec(4'd7,1'b1,8'd20), rec(4'd7,1'b0,8'd20),
                    rec(4'd6,1'b1,8'd10), rec(4'd6,1'b0,8'd10), rec(4'd5,1'b1,8'd10),
                    rec(4'd5,1'b0,8'd10)};
    vecs[1].ovf  = 1'b0;

    vecs[2].w    = {8'd200, 8'd200, 8'd200, 8'd200};
    vecs[2].info = {rec(4'hF,1'b1,8'd255), rec(4'd7,1'b1,8'd255), rec(4'd7,1'b0,8'd255),
                    rec(4'd6,1'b1,8'd200), rec(4'd6,1'b0,8'd200), rec(4'd5,1'b1,8'd200),
                    rec(4'd5,1'b0,8'd200)};
    vecs[2].ovf  = 1'b1;

    vecs[3].w    = {8'd4, 8'd3, 8'd2, 8'd1};
    vecs[3].info = {rec(4'hF,1'b1,8'd10), rec(4'd7,1'b1,8'd6), rec(4'd6,1'b1,8'd3),
                    rec(4'd7,1'b0,8'd4), rec(4'd6,1'b0,8'd3), rec(4'd5,1'b1,8'd2),
                    rec(4'd5,1'b0,8'd1)};
    vecs[3].ovf  = 1'b0;

    vecs[4].w    = {8'd3, 8'd0, 8'd7, 8'd0};
    vecs[4].info = {rec(4'hF,1'b1,8'd10), rec(4'd7,1'b0,8'd3), rec(4'd6,1'b0,8'd0),
                    rec(4'd6,1'b1,8'd3), rec(4'd5,1'b1,8'd0), rec(4'd7,1'b1,8'd7),
                    rec(4'd5,1'b0,8'd0)};
    vecs[4].ovf  = 1'b0;

    rst         = 1'b1;
    start       = 1'b0;
    leaf_valid  = 1'b0;
    leaf_weight = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // leaf_valid outside LOAD must not disturb the idle table
    leaf_valid  = 1'b1;
    leaf_weight = 8'd77;
    repeat (2) @(negedge clk);
    check("idle leaf ignored", 128'(info_nodes), 128'(0));
    leaf_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_vector(i, (i == 1), (i == 2));
    end

    // Abandon a build during the second scan with an async reset
    pulse_start(0);
    load_leaves(0, 1'b0, accepted);
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst        = 1'b1;
    leaf_valid = 1'b0;
    #1;
    check_reset_values("mid-build reset");
    @(negedge clk);
    rst = 1'b0;
    run_vector(3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
